mac_stream_seq: RTL and testbench

- Sequencer and datapath that drives one dot-product (neuron) evaluation end to end.
- Accepts a start command with a vector length, then consumes that many signed (w, x) pairs over a valid/ready stream.
- Accumulates the products, applies ReLU with scale-down and saturation to WIDTH bits, and presents the result on a valid/ready output.
- It is the initiator-side companion of the MAC/ReLU datapath: it owns enable, clear and result capture that the MAC leaves to its environment.

---
 rtl/mac_stream_seq_if.sv | 31 +++
 rtl/mac_stream_seq.sv | 118 +++++++++++
 tb/tb_mac_stream_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mac_stream_seq_if.sv
// Command, pair-stream and result-stream bundle for the MAC/ReLU sequencer.
// The master drives commands, pairs and result acceptance; the slave is the sequencer.
interface mac_stream_seq_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int ACC_W = 2*WIDTH + LEN_W
);
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     busy;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  w;
    logic signed [WIDTH-1:0]  x;

    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic signed [ACC_W-1:0]  acc_out;

    modport master (
        output start, len, in_valid, w, x, out_ready,
        input  busy, in_ready, out_valid, out_data, acc_out
    );

    modport slave (
        input  start, len, in_valid, w, x, out_ready,
        output busy, in_ready, out_valid, out_data, acc_out
    );
endinterface

// File: rtl/mac_stream_seq.sv
// Dot-product sequencer: start+len, then len signed (w,x) pairs; emits ReLU(acc>>>SHIFT) saturated to WIDTH.
// Result valid the cycle after the last pair (or after start when len=0); held until out_ready, pairs refused meanwhile.
module mac_stream_seq #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int ACC_W = 2*WIDTH + LEN_W,
    parameter int SHIFT = 7
) (
    input  logic             clk,
    input  logic             rst,
    mac_stream_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    localparam logic signed [ACC_W-1:0] SAT = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    state_t                   state;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         count;
    logic signed [ACC_W-1:0]  acc;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic [WIDTH-1:0]         out_data_q;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [WIDTH-1:0]          relu;
    logic                      fire_in;
    logic                      fire_out;
    logic                      last_pair;

    assign prod     = bus.w * bus.x;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign acc_sum  = acc + prod_ext;
    assign shifted  = acc_sum >>> SHIFT;

    // Result is formed from the sum including the final pair, so it can be registered on the same edge.
    always_comb begin
        relu = '0;
        if (acc_sum[ACC_W-1] || (acc_sum == '0))
            relu = '0;
        else if (shifted > SAT)
            relu = '1;
        else
            relu = shifted[WIDTH-1:0];
    end

    assign fire_in   = (state == ACCUM) && in_ready_q && bus.in_valid;
    assign fire_out  = out_valid_q && bus.out_ready;
    assign last_pair = ((count + LEN_W'(1)) == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            count       <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            len_q      <= bus.len;
                            in_ready_q <= 1'b1;
                            state      <= ACCUM;
                        end else begin
                            out_data_q  <= '0;
                            out_valid_q <= 1'b1;
                            state       <= OUTPUT;
                        end
                    end
                end
                ACCUM: begin
                    if (fire_in) begin
                        acc   <= acc_sum;
                        count <= count + LEN_W'(1);
                        if (last_pair) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= relu;
                            state       <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (fire_out) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.acc_out   = acc;

endmodule

// File: tb/tb_mac_stream_seq.sv
// Directed bench for mac_stream_seq with hand-computed dot products (WIDTH=8, SHIFT=7).
module tb_mac_stream_seq;
    localparam int WIDTH = 8;
    localparam int LEN_W = 8;
    localparam int ACC_W = 2*WIDTH + LEN_W;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mac_stream_seq_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    mac_stream_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ACC_W(ACC_W), .SHIFT(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic pair(input int wv, input int xv);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("pair_in_ready", int'(bus.in_ready), 1);
        bus.w        = 8'(wv);
        bus.x        = 8'(xv);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic cmd(input int l);
        bus.start = 1'b1;
        bus.len   = 8'(l);
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.w         = '0;
        bus.x         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_acc", int'(bus.acc_out), 0);
        rst = 1'b0;
        tick();

        // Run 1: 2 x (64*64) = 8192 -> 64, one-cycle valid with out_ready high
        bus.out_ready = 1'b1;
        cmd(2);
        chk("r1_busy", int'(bus.busy), 1);
        chk("r1_in_ready", int'(bus.in_ready), 1);
        pair(64, 64);
        chk("r1_early_valid", int'(bus.out_valid), 0);
        pair(64, 64);
        chk("r1_out_valid", int'(bus.out_valid), 1);
        chk("r1_out_data", int'(bus.out_data), 64);
        chk("r1_acc", int'(bus.acc_out), 8192);
        chk("r1_in_ready_out", int'(bus.in_ready), 0);
        tick();
        chk("r1_valid_drop", int'(bus.out_valid), 0);
        chk("r1_busy_drop", int'(bus.busy), 0);
        chk("r1_acc_kept", int'(bus.acc_out), 8192);

        // Run 2: 4 x (127*127) = 64516 -> 504 saturates to 255; stray start mid-run ignored
        cmd(4);
        pair(127, 127);
        bus.start = 1'b1;
        bus.len   = 8'd1;
        pair(127, 127);
        bus.start = 1'b0;
        chk("r2_start_ignored_rdy", int'(bus.in_ready), 1);
        chk("r2_start_ignored_vld", int'(bus.out_valid), 0);
        pair(127, 127);
        chk("r2_mid_valid", int'(bus.out_valid), 0);
        pair(127, 127);
        chk("r2_out_valid", int'(bus.out_valid), 1);
        chk("r2_out_data", int'(bus.out_data), 255);
        chk("r2_acc", int'(bus.acc_out), 64516);
        tick();
        chk("r2_idle", int'(bus.busy), 0);

        // Run 3: -5000 + 100 - 1 = -4901 -> ReLU clamps to 0
        cmd(3);
        pair(-100, 50);
        pair(10, 10);
        pair(-1, 1);
        chk("r3_out_valid", int'(bus.out_valid), 1);
        chk("r3_out_data", int'(bus.out_data), 0);
        chk("r3_acc", int'(bus.acc_out), -4901);
        tick();

        // Run 4: bubbles, 200 - 20 + 9 = 189 -> 1, consumer stalls 3 cycles
        bus.out_ready = 1'b0;
        cmd(3);
        pair(10, 20);
        tick();
        pair(-5, 4);
        tick();
        tick();
        chk("r4_bubble_acc", int'(bus.acc_out), 180);
        pair(3, 3);
        chk("r4_out_valid", int'(bus.out_valid), 1);
        chk("r4_out_data", int'(bus.out_data), 1);
        chk("r4_acc", int'(bus.acc_out), 189);
        bus.in_valid = 1'b1;
        bus.w        = 8'sd100;
        bus.x        = 8'sd100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r4_hold_valid", int'(bus.out_valid), 1);
            chk("r4_hold_data", int'(bus.out_data), 1);
            chk("r4_hold_in_ready", int'(bus.in_ready), 0);
            chk("r4_hold_acc", int'(bus.acc_out), 189);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("r4_valid_drop", int'(bus.out_valid), 0);
        chk("r4_acc_kept", int'(bus.acc_out), 189);

        // Run 5: len=0 -> immediate zero result, acc cleared
        cmd(0);
        chk("r5_out_valid", int'(bus.out_valid), 1);
        chk("r5_out_data", int'(bus.out_data), 0);
        chk("r5_acc", int'(bus.acc_out), 0);
        chk("r5_in_ready", int'(bus.in_ready), 0);
        tick();
        chk("r5_valid_drop", int'(bus.out_valid), 0);

        // Run 6: reset after 2 of 5 pairs, then len=1 with (2,-3)
        cmd(5);
        pair(10, 10);
        pair(10, 10);
        chk("r6_partial_acc", int'(bus.acc_out), 200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r6_rst_busy", int'(bus.busy), 0);
        chk("r6_rst_acc", int'(bus.acc_out), 0);
        chk("r6_rst_valid", int'(bus.out_valid), 0);
        chk("r6_rst_in_ready", int'(bus.in_ready), 0);
        tick();
        chk("r6_no_output", int'(bus.out_valid), 0);
        cmd(1);
        pair(2, -3);
        chk("r6_out_valid", int'(bus.out_valid), 1);
        chk("r6_out_data", int'(bus.out_data), 0);
        chk("r6_acc", int'(bus.acc_out), -6);
        tick();
        chk("r6_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
